// File: rtl/parallel_to_serial_shifter_pkg.sv
// Shared definitions for the parallel-to-serial shifter: state encoding,
// default word width (matches the upstream register stage) and counter sizing.
package parallel_to_serial_shifter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // One spare bit so the counter can never alias WIDTH-1 back to zero.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/parallel_to_serial_shifter_if.sv
// Word-in / bit-out handshake between the register stage and the serializer.
interface parallel_to_serial_shifter_if
  import parallel_to_serial_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] d;
  logic             start;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output d, start,
    input  ready, sout, sout_valid, done
  );

  modport slave (
    input  d, start,
    output ready, sout, sout_valid, done
  );
endinterface

// File: rtl/parallel_to_serial_shifter_bit_counter.sv
// Bit position counter for the serializer; tc flags the last bit of a word.
module parallel_to_serial_shifter_bit_counter
  import parallel_to_serial_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == CW'(WIDTH - 1));
endmodule

// File: rtl/parallel_to_serial_shifter.sv
// Serializes one parallel word per start strobe onto sout; all outputs are
// registered and the whole datapath returns to idle on an asynchronous reset.
module parallel_to_serial_shifter
  import parallel_to_serial_shifter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                         clk,
  input logic                         rst,
  parallel_to_serial_shifter_if.slave bus
);
  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sr_reg;
  logic             sout_reg;
  logic             valid_reg;
  logic             done_reg;
  logic             ready_reg;

  logic             cnt_tc;
  logic             d_first;
  logic             sr_first;
  logic [WIDTH-1:0] d_shifted;
  logic [WIDTH-1:0] sr_shifted;

  // The first bit goes straight to sout on accept; the register holds the rest.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign d_first    = bus.d[0];
      assign d_shifted  = {1'b0, bus.d[WIDTH-1:1]};
      assign sr_first   = sr_reg[0];
      assign sr_shifted = {1'b0, sr_reg[WIDTH-1:1]};
    end else begin : g_msb
      assign d_first    = bus.d[WIDTH-1];
      assign d_shifted  = {bus.d[WIDTH-2:0], 1'b0};
      assign sr_first   = sr_reg[WIDTH-1];
      assign sr_shifted = {sr_reg[WIDTH-2:0], 1'b0};
    end
  endgenerate

  parallel_to_serial_shifter_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (state_reg != ST_SHIFT),
    .en    ((state_reg == ST_SHIFT) && !cnt_tc),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      sr_reg    <= '0;
      sout_reg  <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_reg <= ST_SHIFT;
            sr_reg    <= d_shifted;
            sout_reg  <= d_first;
            valid_reg <= 1'b1;
            ready_reg <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cnt_tc) begin
            state_reg <= ST_DONE;
            sr_reg    <= '0;
            sout_reg  <= 1'b0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            sr_reg    <= sr_shifted;
            sout_reg  <= sr_first;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fall back to the reset picture.
          state_reg <= ST_IDLE;
          sr_reg    <= '0;
          sout_reg  <= 1'b0;
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready      = ready_reg;
  assign bus.sout       = sout_reg;
  assign bus.sout_valid = valid_reg;
  assign bus.done       = done_reg;
endmodule

// File: tb/tb_parallel_to_serial_shifter.sv
// Directed bench for parallel_to_serial_shifter: one LSB-first and one
// MSB-first instance on a shared clock/reset, checked at the falling edge.
module tb_parallel_to_serial_shifter;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  parallel_to_serial_shifter_if #(.WIDTH(4)) ifl ();
  parallel_to_serial_shifter_if #(.WIDTH(4)) ifm ();

  parallel_to_serial_shifter #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (ifl)
  );

  parallel_to_serial_shifter #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (ifm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed status vectors below are {sout, sout_valid, ready, done}.

  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b1;
    ifl.d = 4'b0000; ifl.start = 1'b0;
    ifm.d = 4'b0000; ifm.start = 1'b0;
    #2;
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0010) begin
      tests_failed++;
      $display("FAIL reset_lsb: got %b expected %b", got, 4'b0010);
    end
    got = {ifm.sout, ifm.sout_valid, ifm.ready, ifm.done};
    tests_run++;
    if (got !== 4'b0010) begin
      tests_failed++;
      $display("FAIL reset_msb: got %b expected %b", got, 4'b0010);
    end
    #10;
    rst = 1'b0;
    $display("[TB] reset: outputs at idle values");
  endtask

  task automatic test_lsb_word();
    logic [0:3] exp_bits;
    logic [3:0] got;
    exp_bits = 4'b1010;
    @(negedge clk);
    ifl.d = 4'b0101; ifl.start = 1'b1;
    @(negedge clk);
    ifl.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
      tests_run++;
      if (got !== {exp_bits[k], 3'b100}) begin
        tests_failed++;
        $display("FAIL lsb_bit%0d: got %b expected %b", k, got, {exp_bits[k], 3'b100});
      end
      @(negedge clk);
    end
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0001) begin
      tests_failed++;
      $display("FAIL lsb_done: got %b expected %b", got, 4'b0001);
    end
    @(negedge clk);
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0010) begin
      tests_failed++;
      $display("FAIL lsb_ready: got %b expected %b", got, 4'b0010);
    end
    $display("[TB] lsb word D=0101 serialized");
  endtask

  task automatic test_msb_word();
    logic [0:3] exp_bits;
    logic [3:0] got;
    exp_bits = 4'b1001;
    @(negedge clk);
    ifm.d = 4'b1001; ifm.start = 1'b1;
    @(negedge clk);
    ifm.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = {ifm.sout, ifm.sout_valid, ifm.ready, ifm.done};
      tests_run++;
      if (got !== {exp_bits[k], 3'b100}) begin
        tests_failed++;
        $display("FAIL msb_bit%0d: got %b expected %b", k, got, {exp_bits[k], 3'b100});
      end
      if (k == 0) ifm.d = 4'b1111;
      @(negedge clk);
    end
    got = {ifm.sout, ifm.sout_valid, ifm.ready, ifm.done};
    tests_run++;
    if (got !== 4'b0001) begin
      tests_failed++;
      $display("FAIL msb_done: got %b expected %b", got, 4'b0001);
    end
    @(negedge clk);
    got = {ifm.sout, ifm.sout_valid, ifm.ready, ifm.done};
    tests_run++;
    if (got !== 4'b0010) begin
      tests_failed++;
      $display("FAIL msb_ready: got %b expected %b", got, 4'b0010);
    end
    $display("[TB] msb word D=1001 serialized, mid-shift D change ignored");
  endtask

  task automatic test_ignore_start();
    logic [0:3] exp_bits;
    logic [3:0] got;
    exp_bits = 4'b0110;
    @(negedge clk);
    ifl.d = 4'b0110; ifl.start = 1'b1;
    @(negedge clk);
    ifl.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
      tests_run++;
      if (got !== {exp_bits[k], 3'b100}) begin
        tests_failed++;
        $display("FAIL ign_bit%0d: got %b expected %b", k, got, {exp_bits[k], 3'b100});
      end
      if (k == 1) ifl.start = 1'b1;
      if (k == 2) ifl.start = 1'b0;
      @(negedge clk);
    end
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0001) begin
      tests_failed++;
      $display("FAIL ign_done: got %b expected %b", got, 4'b0001);
    end
    ifl.start = 1'b1;
    @(negedge clk);
    ifl.start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
      tests_run++;
      if (got !== 4'b0010) begin
        tests_failed++;
        $display("FAIL ign_idle%0d: got %b expected %b", c, got, 4'b0010);
      end
      @(negedge clk);
    end
    $display("[TB] start during shift/done ignored, single done pulse");
  endtask

  task automatic test_reset_mid_shift();
    logic [0:3] exp_bits;
    logic [3:0] got;
    exp_bits = 4'b1100;
    @(negedge clk);
    ifl.d = 4'b1111; ifl.start = 1'b1;
    @(negedge clk);
    ifl.start = 1'b0;
    @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0010) begin
      tests_failed++;
      $display("FAIL midrst_async: got %b expected %b", got, 4'b0010);
    end
    @(negedge clk);
    rst = 1'b0;
    ifl.d = 4'b0011; ifl.start = 1'b1;
    @(negedge clk);
    ifl.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
      tests_run++;
      if (got !== {exp_bits[k], 3'b100}) begin
        tests_failed++;
        $display("FAIL midrst_bit%0d: got %b expected %b", k, got, {exp_bits[k], 3'b100});
      end
      @(negedge clk);
    end
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0001) begin
      tests_failed++;
      $display("FAIL midrst_done: got %b expected %b", got, 4'b0001);
    end
    @(negedge clk);
    $display("[TB] async reset mid-shift, then clean D=0011 word");
  endtask

  task automatic test_back_to_back();
    logic [0:3] exp_a;
    logic [0:3] exp_b;
    logic [3:0] got;
    exp_a = 4'b1010;
    exp_b = 4'b0101;
    @(negedge clk);
    ifl.d = 4'b0101; ifl.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
      tests_run++;
      if (got !== {exp_a[k], 3'b100}) begin
        tests_failed++;
        $display("FAIL b2b_a_bit%0d: got %b expected %b", k, got, {exp_a[k], 3'b100});
      end
      if (k == 0) ifl.d = 4'b1010;
      @(negedge clk);
    end
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0001) begin
      tests_failed++;
      $display("FAIL b2b_a_done: got %b expected %b", got, 4'b0001);
    end
    @(negedge clk);
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0010) begin
      tests_failed++;
      $display("FAIL b2b_gap: got %b expected %b", got, 4'b0010);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
      tests_run++;
      if (got !== {exp_b[k], 3'b100}) begin
        tests_failed++;
        $display("FAIL b2b_b_bit%0d: got %b expected %b", k, got, {exp_b[k], 3'b100});
      end
      if (k == 0) ifl.start = 1'b0;
      @(negedge clk);
    end
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0001) begin
      tests_failed++;
      $display("FAIL b2b_b_done: got %b expected %b", got, 4'b0001);
    end
    @(negedge clk);
    got = {ifl.sout, ifl.sout_valid, ifl.ready, ifl.done};
    tests_run++;
    if (got !== 4'b0010) begin
      tests_failed++;
      $display("FAIL b2b_end: got %b expected %b", got, 4'b0010);
    end
    $display("[TB] back-to-back words 0101 and 1010, accepts 6 cycles apart");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_lsb_word();
    test_msb_word();
    test_ignore_start();
    test_reset_mid_shift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
